mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Pipeline boundary between the MEM stage and writeback in the RV32I pipeline. Consumes the MEM stage's instruction, effective address and raw data-cache word, waits out multi-cycle cache accesses, and extracts and sign/zero-extends load data. Buffers a completed access while the rest of the pipeline is frozen. Presents a registered MEM/WB bundle to writeback.

## Interface
- (no parameters; data width fixed at 32)

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- valid_in  in  1  MEM stage holds a real instruction (0 = bubble)
- ctrl_in  in  rv32i_control_word  control word from MEM; only ctrl_in.mem.read / ctrl_in.mem.write are interpreted, whole word is forwarded
- pc_in  in  32  instruction PC
- ir_in  in  32  instruction word; ir_in[6:0] opcode, ir_in[14:12] load funct3
- addr_in  in  32  effective address for loads/stores, ALU result otherwise
- dcache_rdata  in  32  word containing the addressed byte (word-aligned data)
- dcache_resp  in  1  data cache completes current access this cycle
- stall_in  in  1  freeze request from hazard unit (excludes this block's own mem_stall)
- flush  in  1  instruction leaving MEM is squashed
- mem_stall  out  1  combinational: pipeline must hold, access outstanding
- mem_done  out  1  registered: access for current MEM instruction already complete; MEM gates dcache_read/write with ~mem_done
- valid_out  out  1  registered: wb bundle valid
- ctrl_out  out  rv32i_control_word  registered control word
- pc_out, ir_out  out  32  registered
- wb_data  out  32  registered: aligned load result or addr_in pass-through

## Operation
- memop = valid_in & (ctrl_in.mem.read | ctrl_in.mem.write); load = valid_in & ctrl_in.mem.read.
- FSM states IDLE, WAIT, HELD. Reset -> IDLE.
- IDLE: memop & ~dcache_resp -> WAIT. memop & dcache_resp & stall_in -> capture into buffer, HELD. memop & dcache_resp & ~stall_in -> advance, stay IDLE. Non-memop: advance if ~stall_in.
- WAIT: dcache_resp & ~stall_in -> advance, IDLE. dcache_resp & stall_in -> buffer, HELD. Else stay.
- HELD: ~stall_in -> advance from buffer, IDLE. Else stay; dcache_resp ignored.
- mem_stall = memop & ~dcache_resp & (state != HELD).
- mem_done = (state == HELD).
- Advance: load bundle register with valid_in & ~flush, ctrl_in, pc_in, ir_in, and wb_data. When flush, valid_out=0 and ctrl_out='0. A flush does not abort an outstanding access; it only squashes the entry when it advances.
- Buffer: holds extracted load data, captured at the dcache_resp edge. Non-load memops (stores) buffer nothing, but still use HELD.
- Load extraction, off = addr_in[1:0]:
  - lb: sign-extend byte off.
  - lbu: zero-extend byte off.
  - lh: sign-extend half addr_in[1].
  - lhu: zero-extend half addr_in[1].
  - lw: whole word.
  - Undefined funct3: whole word.
  - addr_in[0] is ignored for halves; misalignment is not trapped.
- Non-load: wb_data = addr_in.
- dcache_resp in IDLE with no memop: ignored.

## Timing
- Reset values: state IDLE, valid_out 0, ctrl_out '0, pc_out 0, ir_out 0, wb_data 0, mem_done 0, buffer 0.
- While rst is low, mem_stall is 0.
- Hit (resp same cycle as memop, no stall): bundle visible 1 cycle later; mem_stall never asserts.
- N-cycle miss: mem_stall high for N cycles, falling combinationally in the resp cycle; bundle appears the cycle after resp.
- Outputs hold their value whenever no advance occurs.
- Reset mid-WAIT/HELD: return to IDLE next edge and discard the access and buffer. A late resp is ignored unless a new memop is present.
- Simultaneous stall_in and flush: stall wins; flush must be re-presented at the advance cycle.

## Test plan
- Reset with all inputs toggling -> valid_out=0, wb_data=0, mem_stall=0, mem_done=0 held through reset; first ALU op addr_in=0x1234 after reset -> wb_data=0x00001234, valid_out=1 next cycle.
- lb, addr_in=0x1003, dcache_rdata=0x80FF7F01, resp same cycle -> wb_data=0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x1002 -> 0xFFFF80FF; lhu -> 0x000080FF; lw -> 0x80FF7F01.
- lw miss, resp after 3 cycles -> mem_stall=1 for exactly 3 cycles, 0 in resp cycle; valid_out rises the following cycle with the word.
- lw resp while stall_in=1 for 4 more cycles -> mem_done=1 and mem_stall=0 during hold; extra resp pulses ignored; after stall_in drops, wb_data = originally captured word.
- Store with flush=1 at completion -> valid_out=0, ctrl_out='0; following instruction advances normally.
- rst asserted in WAIT, then resp arrives with valid_in=0 -> state IDLE, no valid_out, mem_stall=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ============================================================================
//  Module   : mem_wb_stage
//  Brief    : MEM/WB pipeline boundary; waits out data-cache accesses, aligns
//             load data and holds a completed access while the pipe is frozen.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

    typedef struct packed {
        logic read;
        logic write;
    } mem_ctrl_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       branch;
        logic       jump;
        mem_ctrl_t  mem;
    } rv32i_control_word;

endpackage

module mem_wb_stage
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  rv32i_control_word ctrl_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       ir_in,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       dcache_rdata,
    input  logic              dcache_resp,
    input  logic              stall_in,
    input  logic              flush,
    output logic              mem_stall,
    output logic              mem_done,
    output logic              valid_out,
    output rv32i_control_word ctrl_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       ir_out,
    output logic [31:0]       wb_data
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_HELD = 2'd2;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [31:0]       r_buf;
    logic              r_valid;
    rv32i_control_word r_ctrl;
    logic [31:0]       r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_wb;

    logic              w_memop;
    logic              w_load;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [31:0]       w_wb_next;
    logic              w_advance;
    logic              w_capture;
    logic              w_from_buf;
    logic              w_stall;

    assign w_memop = valid_in & (ctrl_in.mem.read | ctrl_in.mem.write);
    assign w_load  = valid_in & ctrl_in.mem.read;

    // Cache returns the whole aligned word; select the addressed lane.
    always_comb begin
        w_byte = dcache_rdata[7:0];
        case (addr_in[1:0])
            2'd0:    w_byte = dcache_rdata[7:0];
            2'd1:    w_byte = dcache_rdata[15:8];
            2'd2:    w_byte = dcache_rdata[23:16];
            default: w_byte = dcache_rdata[31:24];
        endcase
    end

    assign w_half = addr_in[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];

    always_comb begin
        w_load_data = dcache_rdata;
        case (ir_in[14:12])
            c_F3_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: w_load_data = {24'd0, w_byte};
            c_F3_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = dcache_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_memop) begin
                    if (!dcache_resp) begin
                        w_state_nxt = c_WAIT;
                    end else if (stall_in) begin
                        w_state_nxt = c_HELD;
                    end
                end
            end
            c_WAIT: begin
                if (dcache_resp) begin
                    w_state_nxt = stall_in ? c_HELD : c_IDLE;
                end
            end
            c_HELD: begin
                if (!stall_in) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_advance  = 1'b0;
        w_capture  = 1'b0;
        w_from_buf = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_advance = w_memop ? (dcache_resp & ~stall_in) : ~stall_in;
                w_capture = w_memop & dcache_resp & stall_in;
                w_stall   = w_memop & ~dcache_resp;
            end
            c_WAIT: begin
                w_advance = dcache_resp & ~stall_in;
                w_capture = dcache_resp & stall_in;
                w_stall   = w_memop & ~dcache_resp;
            end
            c_HELD: begin
                // The cache is done with this access; late responses are ignored.
                w_advance  = ~stall_in;
                w_from_buf = 1'b1;
            end
            default: begin
                w_advance = 1'b0;
            end
        endcase
    end

    assign w_wb_next = w_load ? (w_from_buf ? r_buf : w_load_data) : addr_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf   <= 32'd0;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_pc    <= 32'd0;
            r_ir    <= 32'd0;
            r_wb    <= 32'd0;
        end else begin
            if (w_capture && w_load) begin
                r_buf <= w_load_data;
            end
            if (w_advance) begin
                r_valid <= valid_in & ~flush;
                r_ctrl  <= flush ? '0 : ctrl_in;
                r_pc    <= pc_in;
                r_ir    <= ir_in;
                r_wb    <= w_wb_next;
            end
        end
    end

    assign mem_stall = rst & w_stall;
    assign mem_done  = (r_state == c_HELD);
    assign valid_out = r_valid;
    assign ctrl_out  = r_ctrl;
    assign pc_out    = r_pc;
    assign ir_out    = r_ir;
    assign wb_data   = r_wb;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Brief    : Self-checking bench for mem_wb_stage: load-alignment table,
//             multi-cycle corner sequences and randomized pipeline traffic.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;
    import rv32i_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    rv32i_control_word ctrl_in;
    logic [31:0]       pc_in;
    logic [31:0]       ir_in;
    logic [31:0]       addr_in;
    logic [31:0]       dcache_rdata;
    logic              dcache_resp;
    logic              stall_in;
    logic              flush;
    logic              mem_stall;
    logic              mem_done;
    logic              valid_out;
    rv32i_control_word ctrl_out;
    logic [31:0]       pc_out;
    logic [31:0]       ir_out;
    logic [31:0]       wb_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] pc_cnt = 32'h0000_0100;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .ctrl_in      (ctrl_in),
        .pc_in        (pc_in),
        .ir_in        (ir_in),
        .addr_in      (addr_in),
        .dcache_rdata (dcache_rdata),
        .dcache_resp  (dcache_resp),
        .stall_in     (stall_in),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .valid_out    (valid_out),
        .ctrl_out     (ctrl_out),
        .pc_out       (pc_out),
        .ir_out       (ir_out),
        .wb_data      (wb_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic rsp, input logic stl, input logic fl);
        valid_in          = v;
        ctrl_in           = '0;
        ctrl_in.mem.read  = rd;
        ctrl_in.mem.write = wr;
        ctrl_in.reg_write = ~wr;
        ctrl_in.alu_op    = 4'h3;
        pc_in             = pc_cnt;
        pc_cnt            = pc_cnt + 32'd4;
        ir_in             = {17'd0, f3, 5'd1, 7'b0000011};
        addr_in           = a;
        dcache_rdata      = d;
        dcache_resp       = rsp;
        stall_in          = stl;
        flush             = fl;
    endtask

    // Reference for load alignment, computed arithmetically from the access rules.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * a[1:0])) % 256;
        h = (w >> (16 * a[1])) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? (32'(b) - 32'd256) : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 32768) ? (32'(h) - 32'h0001_0000) : 32'(h);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    // Behavioural model: an access is either finished-and-parked or not; the
    // pipeline upstream keeps MEM inputs frozen until the entry retires.
    logic              m_parked;
    logic [31:0]       m_kept;
    logic              m_valid;
    rv32i_control_word m_ctrl;
    logic [31:0]       m_pc;
    logic [31:0]       m_ir;
    logic [31:0]       m_wb;
    logic              frozen;

    task automatic model_reset();
        m_parked = 1'b0;
        m_kept   = 32'd0;
        m_valid  = 1'b0;
        m_ctrl   = '0;
        m_pc     = 32'd0;
        m_ir     = 32'd0;
        m_wb     = 32'd0;
        frozen   = 1'b0;
    endtask

    task automatic model_edge();
        logic        memop;
        logic        load;
        logic        retire;
        logic [31:0] d;
        memop  = valid_in && (ctrl_in.mem.read || ctrl_in.mem.write);
        load   = valid_in && ctrl_in.mem.read;
        retire = 1'b0;
        d      = addr_in;
        if (!rst) begin
            model_reset();
        end else begin
            if (m_parked) begin
                if (!stall_in) begin
                    retire   = 1'b1;
                    d        = m_kept;
                    m_parked = 1'b0;
                end
            end else if (memop) begin
                if (dcache_resp) begin
                    d = load ? ref_load(ir_in[14:12], addr_in, dcache_rdata) : addr_in;
                    if (stall_in) begin
                        m_parked = 1'b1;
                        m_kept   = d;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end else if (!stall_in) begin
                retire = 1'b1;
            end
            if (retire) begin
                m_valid = valid_in && !flush;
                m_ctrl  = flush ? '0 : ctrl_in;
                m_pc    = pc_in;
                m_ir    = ir_in;
                m_wb    = load ? d : addr_in;
            end
            frozen = !retire;
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_1003, 32'hFFFF_FF80};
        vecs[1]  = '{3'b100, 32'h0000_1003, 32'h0000_0080};
        vecs[2]  = '{3'b001, 32'h0000_1002, 32'hFFFF_80FF};
        vecs[3]  = '{3'b101, 32'h0000_1002, 32'h0000_80FF};
        vecs[4]  = '{3'b010, 32'h0000_1000, 32'h80FF_7F01};
        vecs[5]  = '{3'b000, 32'h0000_1001, 32'h0000_007F};
        vecs[6]  = '{3'b100, 32'h0000_1002, 32'h0000_00FF};
        vecs[7]  = '{3'b001, 32'h0000_1000, 32'h0000_7F01};
        vecs[8]  = '{3'b001, 32'h0000_1003, 32'hFFFF_80FF};
        vecs[9]  = '{3'b011, 32'h0000_1001, 32'h80FF_7F01};
        vecs[10] = '{3'b101, 32'h0000_1001, 32'h0000_7F01};
        vecs[11] = '{3'b111, 32'h0000_1002, 32'h80FF_7F01};

        rst = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom,
                1'($urandom), 1'($urandom), 1'($urandom));
            dcache_resp = 1'b0;
            #1;
            chk("reset mem_stall", {31'd0, mem_stall}, 32'd0);
            @(negedge clk);
            chk("reset valid_out", {31'd0, valid_out}, 32'd0);
            chk("reset wb_data", wb_data, 32'd0);
            chk("reset mem_done", {31'd0, mem_done}, 32'd0);
        end

        rst = 1'b1;
        drv(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("alu mem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        chk("alu wb_data", wb_data, 32'h0000_1234);
        chk("alu valid_out", {31'd0, valid_out}, 32'd1);
        chk("alu pc_out", pc_out, pc_cnt - 32'd4);

        // Load alignment table, all cache hits.
        for (int i = 0; i < 12; i++) begin
            drv(1'b1, 1'b1, 1'b0, vecs[i].f3, vecs[i].addr, 32'h80FF_7F01, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("hit%0d mem_stall", i), {31'd0, mem_stall}, 32'd0);
            @(negedge clk);
            chk($sformatf("hit%0d wb_data", i), wb_data, vecs[i].exp);
            chk($sformatf("hit%0d valid_out", i), {31'd0, valid_out}, 32'd1);
        end

        // lw miss with response three cycles late.
        drv(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            dcache_rdata = $urandom;
            #1;
            chk($sformatf("miss cyc%0d mem_stall", k), {31'd0, mem_stall}, 32'd1);
            @(negedge clk);
            chk($sformatf("miss cyc%0d valid_out", k), {31'd0, valid_out}, 32'd0);
        end
        dcache_resp  = 1'b1;
        dcache_rdata = 32'h1234_5678;
        #1;
        chk("miss resp mem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        chk("miss valid_out", {31'd0, valid_out}, 32'd1);
        chk("miss wb_data", wb_data, 32'h1234_5678);

        // lw completes under stall_in, held four more cycles with stray responses.
        drv(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'hCAFE_BABE, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("held capture mem_done", {31'd0, mem_done}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            dcache_resp  = k[0];
            dcache_rdata = 32'hDEAD_0000 + 32'(k);
            #1;
            chk($sformatf("held%0d mem_stall", k), {31'd0, mem_stall}, 32'd0);
            chk($sformatf("held%0d mem_done", k), {31'd0, mem_done}, 32'd1);
            @(negedge clk);
            chk($sformatf("held%0d valid_out", k), {31'd0, valid_out}, 32'd0);
        end
        stall_in    = 1'b0;
        dcache_resp = 1'b0;
        @(negedge clk);
        chk("held release wb_data", wb_data, 32'hCAFE_BABE);
        chk("held release valid_out", {31'd0, valid_out}, 32'd1);
        chk("held release mem_done", {31'd0, mem_done}, 32'd0);

        // Store flushed at completion, then a normal instruction.
        drv(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush valid_out", {31'd0, valid_out}, 32'd0);
        chk("flush ctrl_out", {20'd0, ctrl_out}, 32'd0);
        drv(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_5555, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post-flush valid_out", {31'd0, valid_out}, 32'd1);
        chk("post-flush ctrl_out", {20'd0, ctrl_out}, {20'd0, ctrl_in});
        chk("post-flush wb_data", wb_data, 32'h0000_5555);

        // Reset while waiting on a miss; late response arrives with no instruction.
        drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst-wait mem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        chk("rst-wait wb_data", wb_data, 32'd0);
        rst = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'h7777_7777, 1'b1, 1'b0, 1'b0);
        #1;
        chk("late resp mem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        chk("late resp valid_out", {31'd0, valid_out}, 32'd0);
        chk("late resp mem_done", {31'd0, mem_done}, 32'd0);
        drv(1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_7000, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post-rst store mem_stall", {31'd0, mem_stall}, 32'd1);
        @(negedge clk);

        // Randomized traffic against the behavioural model.
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic memop_now;
            if (!frozen) begin
                logic [11:0] cbits;
                int unsigned kind;
                cbits      = 12'($urandom);
                ctrl_in    = cbits;
                kind       = $urandom_range(0, 2);
                ctrl_in.mem.read  = (kind == 1);
                ctrl_in.mem.write = (kind == 2);
                valid_in   = ($urandom % 100) < 85;
                pc_in      = $urandom;
                ir_in      = $urandom;
                addr_in    = $urandom;
            end
            dcache_rdata = $urandom;
            dcache_resp  = ($urandom % 100) < 45;
            stall_in     = ($urandom % 100) < 30;
            flush        = ($urandom % 100) < 15;
            rst          = ($urandom % 100) >= 3;
            #1;
            memop_now = valid_in && (ctrl_in.mem.read || ctrl_in.mem.write);
            chk("rand mem_stall", {31'd0, mem_stall},
                {31'd0, rst && memop_now && !dcache_resp && !m_parked});
            chk("rand mem_done", {31'd0, mem_done}, {31'd0, m_parked});
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("rand valid_out", {31'd0, valid_out}, {31'd0, m_valid});
            chk("rand ctrl_out", {20'd0, ctrl_out}, {20'd0, m_ctrl});
            chk("rand pc_out", pc_out, m_pc);
            chk("rand ir_out", ir_out, m_ir);
            chk("rand wb_data", wb_data, m_wb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
